// File: rtl/rns_pkg.sv
// Shared constants, state encoding and constant helpers for the RNS forward converter.
package rns_pkg;

    localparam int unsigned RES_W = 3;

    localparam logic [RES_W-1:0] M0_DEF = 3'd5;
    localparam logic [RES_W-1:0] M1_DEF = 3'd6;
    localparam logic [RES_W-1:0] M2_DEF = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 2^n mod m, evaluated at elaboration time for the two's-complement correction
    function automatic int unsigned pow2_mod(input int unsigned n, input int unsigned m);
        int unsigned r;
        r = 1 % m;
        for (int unsigned i = 0; i < n; i++) begin
            r = (r * 2) % m;
        end
        return r;
    endfunction

endpackage

// File: rtl/rns_mod_dbl_add.sv
// One bit-serial residue step: r_next = (2*r + b) mod M, valid whenever r < M.
module rns_mod_dbl_add
    import rns_pkg::*;
#(
    parameter logic [RES_W-1:0] M = M0_DEF
) (
    input  logic [RES_W-1:0] r,
    input  logic             b,
    output logic [RES_W-1:0] r_next
);

    logic [RES_W:0] t;
    logic [RES_W:0] diff;

    // t <= 2M-1, so one conditional subtract brings it back into range
    always_comb begin
        t      = {r, b};
        diff   = t - {1'b0, M};
        r_next = (t >= {1'b0, M}) ? diff[RES_W-1:0] : t[RES_W-1:0];
    end

endmodule

// File: rtl/rns_fwd_conv.sv
// Bit-serial binary-to-residue converter for moduli {M0, M1, M2}.
// Optional RNS_FWD_SIGNED_EN treats in_data as two's complement and adds a FIX cycle.
module rns_fwd_conv
    import rns_pkg::*;
#(
    parameter int unsigned      DATA_W = 8,
    parameter logic [RES_W-1:0] M0     = M0_DEF,
    parameter logic [RES_W-1:0] M1     = M1_DEF,
    parameter logic [RES_W-1:0] M2     = M2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  res0,
    output logic [RES_W-1:0]  res1,
    output logic [RES_W-1:0]  res2
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t             state;
    state_t             state_n;
    logic [DATA_W-1:0]  sreg;
    logic [CNT_W-1:0]   cnt;
    logic [RES_W-1:0]   nxt0;
    logic [RES_W-1:0]   nxt1;
    logic [RES_W-1:0]   nxt2;

`ifdef RNS_FWD_SIGNED_EN
    localparam logic [RES_W-1:0] K0 = RES_W'(pow2_mod(DATA_W, int'(M0)));
    localparam logic [RES_W-1:0] K1 = RES_W'(pow2_mod(DATA_W, int'(M1)));
    localparam logic [RES_W-1:0] K2 = RES_W'(pow2_mod(DATA_W, int'(M2)));

    logic neg;

    // Subtract 2^DATA_W mod m, wrapping by m, to turn the unsigned residue into the signed one
    function automatic logic [RES_W-1:0] fix_step(input logic [RES_W-1:0] r,
                                                  input logic [RES_W-1:0] m,
                                                  input logic [RES_W-1:0] k);
        logic [RES_W:0] t;
        if (r >= k) t = {1'b0, r} - {1'b0, k};
        else        t = {1'b0, r} + {1'b0, m} - {1'b0, k};
        return t[RES_W-1:0];
    endfunction
`endif

    rns_mod_dbl_add #(.M(M0)) u_ch0 (.r(res0), .b(sreg[DATA_W-1]), .r_next(nxt0));
    rns_mod_dbl_add #(.M(M1)) u_ch1 (.r(res1), .b(sreg[DATA_W-1]), .r_next(nxt1));
    rns_mod_dbl_add #(.M(M2)) u_ch2 (.r(res2), .b(sreg[DATA_W-1]), .r_next(nxt2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = SHIFT;
            end
            SHIFT: begin
`ifdef RNS_FWD_SIGNED_EN
                if (cnt == CNT_W'(1)) state_n = FIX;
`else
                if (cnt == CNT_W'(1)) state_n = DONE;
`endif
            end
            FIX: state_n = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            res0 <= '0;
            res1 <= '0;
            res2 <= '0;
`ifdef RNS_FWD_SIGNED_EN
            neg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg <= in_data;
                        cnt  <= CNT_W'(DATA_W);
                        res0 <= '0;
                        res1 <= '0;
                        res2 <= '0;
`ifdef RNS_FWD_SIGNED_EN
                        neg  <= in_data[DATA_W-1];
`endif
                    end
                end
                SHIFT: begin
                    res0 <= nxt0;
                    res1 <= nxt1;
                    res2 <= nxt2;
                    sreg <= sreg << 1;
                    cnt  <= cnt - 1'b1;
                end
`ifdef RNS_FWD_SIGNED_EN
                FIX: begin
                    if (neg) begin
                        res0 <= fix_step(res0, M0, K0);
                        res1 <= fix_step(res1, M1, K1);
                        res2 <= fix_step(res2, M2, K2);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rns_fwd_conv.sv
// Scoreboard bench for rns_fwd_conv: directed vectors, backpressure, mid-conversion reset, full sweep.
module tb_rns_fwd_conv;

    localparam int unsigned DATA_W = 8;
`ifdef RNS_FWD_SIGNED_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 8;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2:0]        res0, res1, res2;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb_q[$];

    rns_fwd_conv #(.DATA_W(DATA_W), .M0(3'd5), .M1(3'd6), .M2(3'd7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .res0(res0), .res1(res1), .res2(res2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [DATA_W-1:0] x);
        int v;
`ifdef RNS_FWD_SIGNED_EN
        v = int'($signed(x));
`else
        v = int'(x);
`endif
        return {3'(((v % 5) + 5) % 5), 3'(((v % 6) + 6) % 6), 3'(((v % 7) + 7) % 7)};
    endfunction

    // Monitor: residue range every cycle, scoreboard pop on each handoff
    always @(negedge clk) begin
        if (!rst) begin
            chk("range", int'(res0 < 3'd5 && res1 < 3'd6 && res2 < 3'd7), 1);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    chk("residues", int'({res0, res1, res2}), int'(e));
                end
            end
        end
    end

    // Called at posedge+#1 with in_ready high; returns after edge 0 (+#1)
    task automatic accept(input logic [DATA_W-1:0] x, input logic [8:0] e);
        in_valid = 1'b1;
        in_data  = x;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_timeout", int'(out_valid), 1);
    endtask

    task automatic run_one(input string name, input logic [DATA_W-1:0] x, input logic [8:0] e);
        int lat;
        out_ready = 1'b1;
        accept(x, e);
        wait_valid(lat);
        chk({name, "_latency"}, lat, LAT);
        @(posedge clk); #1;
        chk({name, "_valid_pulse"}, int'(out_valid), 0);
        chk({name, "_ready_back"}, int'(in_ready), 1);
    endtask

    initial begin
        logic [8:0] e200, e255, held;
        int lat, w;
`ifdef RNS_FWD_SIGNED_EN
        e200 = {3'd4, 3'd4, 3'd0};
        e255 = {3'd4, 3'd5, 3'd6};
`else
        e200 = {3'd0, 3'd2, 3'd4};
        e255 = {3'd0, 3'd3, 3'd3};
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_res", int'({res0, res1, res2}), 0);
        @(posedge clk); #1;

        run_one("zero", 8'd0, 9'd0);
        run_one("d200", 8'd200, e200);
        run_one("d255", 8'd255, e255);

        // Backpressure: output held, new requests ignored
        out_ready = 1'b0;
        accept(8'd37, {3'd2, 3'd1, 3'd2});
        wait_valid(lat);
        chk("bp_latency", lat, LAT);
        held = {res0, res1, res2};
        chk("bp_value", int'(held), int'({3'd2, 3'd1, 3'd2}));
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", int'(out_valid), 1);
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_res_stable", int'({res0, res1, res2}), int'(held));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", int'(out_valid), 0);
        chk("bp_no_accept", int'(in_ready), 1);

        // Reset in the middle of SHIFT discards the operand
        accept(8'd77, model(8'd77));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        void'(sb_q.pop_back());
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_res", int'({res0, res1, res2}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        run_one("d123", 8'd123, {3'd3, 3'd3, 3'd4});

        // Sweep with random backpressure
        for (int x = 0; x < 256; x++) begin
            w = 0;
            while (!in_ready && w < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                w++;
            end
            chk("sweep_ready_timeout", int'(in_ready), 1);
            accept(8'(x), model(8'(x)));
        end
        out_ready = 1'b1;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
